mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: takes one RV32I memory request at a time, issues a word-aligned
// data-memory access, then returns load data or a store-complete pulse.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    // upstream request
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_is_load_i,
    input  logic        ex_is_store_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [5:0]  ex_reg_id_i,
    // data memory
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    // load writeback
    output logic        is_load_o,
    output logic [31:0] mem_rdata_o,
    output logic [1:0]  mem_wordsize_o,
    output logic [1:0]  reg_op1_2b_o,
    output logic [2:0]  load_instr_o,
    output logic [5:0]  reg_id_o,
    // status
    output logic        store_done_o,
    output logic        misalign_o
);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e      state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        is_load_q, is_load_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  wordsize_q, wordsize_d;
    logic [1:0]  op1_2b_q, op1_2b_d;
    logic [2:0]  load_instr_q, load_instr_d;
    logic [5:0]  reg_id_q, reg_id_d;
    logic        store_done_q, store_done_d;
    logic        misalign_q, misalign_d;
    // decode of the in-flight request, held until the memory responds
    logic        pend_load_q, pend_load_d;
    logic [1:0]  pend_wordsize_q, pend_wordsize_d;
    logic [1:0]  pend_op1_q, pend_op1_d;
    logic [2:0]  pend_instr_q, pend_instr_d;
    logic [5:0]  pend_reg_q, pend_reg_d;

    logic        accept;
    logic        is_byte, is_half, is_word;
    logic        misaligned;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [1:0]  wordsize_c;
    logic [2:0]  instr_c;

    assign ex_ready_o = resetn && (state_q == IDLE);
    assign accept     = ex_valid_i && ex_ready_o && (ex_is_load_i || ex_is_store_i);

    assign is_byte = (ex_funct3_i[1:0] == 2'b00);
    assign is_half = (ex_funct3_i[1:0] == 2'b01);
    assign is_word = !is_byte && !is_half;

    assign misaligned = (is_half && ex_addr_i[0]) || (is_word && (ex_addr_i[1:0] != 2'b00));

    always_comb begin
        wstrb_c    = 4'b1111;
        wdata_c    = ex_wdata_i;
        wordsize_c = 2'd0;
        instr_c    = 3'b000;
        if (is_byte) begin
            wstrb_c    = 4'b0001 << ex_addr_i[1:0];
            wdata_c    = {4{ex_wdata_i[7:0]}};
            wordsize_c = 2'd2;
            instr_c    = 3'b001;
        end else if (is_half) begin
            wstrb_c    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_c    = {2{ex_wdata_i[15:0]}};
            wordsize_c = 2'd1;
            instr_c    = 3'b010;
        end
        if (ex_funct3_i[2]) instr_c = 3'b100;
    end

    always_comb begin
        state_d         = state_q;
        mem_valid_d     = mem_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wstrb_d     = mem_wstrb_q;
        is_load_d       = 1'b0;
        rdata_d         = rdata_q;
        wordsize_d      = wordsize_q;
        op1_2b_d        = op1_2b_q;
        load_instr_d    = load_instr_q;
        reg_id_d        = reg_id_q;
        store_done_d    = 1'b0;
        misalign_d      = 1'b0;
        pend_load_d     = pend_load_q;
        pend_wordsize_d = pend_wordsize_q;
        pend_op1_d      = pend_op1_q;
        pend_instr_d    = pend_instr_q;
        pend_reg_d      = pend_reg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        // load wins when both flags are set
                        state_d         = WAIT;
                        mem_valid_d     = 1'b1;
                        mem_addr_d      = {ex_addr_i[31:2], 2'b00};
                        mem_wstrb_d     = ex_is_load_i ? 4'b0000 : wstrb_c;
                        mem_wdata_d     = ex_is_load_i ? 32'd0 : wdata_c;
                        pend_load_d     = ex_is_load_i;
                        pend_wordsize_d = wordsize_c;
                        pend_op1_d      = ex_addr_i[1:0];
                        pend_instr_d    = instr_c;
                        pend_reg_d      = ex_reg_id_i;
                    end
                end
            end
            WAIT: begin
                if (mem_ready_i) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    if (pend_load_q) begin
                        is_load_d    = 1'b1;
                        rdata_d      = mem_rdata_i;
                        wordsize_d   = pend_wordsize_q;
                        op1_2b_d     = pend_op1_q;
                        load_instr_d = pend_instr_q;
                        reg_id_d     = pend_reg_q;
                    end else begin
                        store_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            mem_valid_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            is_load_q       <= 1'b0;
            rdata_q         <= '0;
            wordsize_q      <= '0;
            op1_2b_q        <= '0;
            load_instr_q    <= '0;
            reg_id_q        <= '0;
            store_done_q    <= 1'b0;
            misalign_q      <= 1'b0;
            pend_load_q     <= 1'b0;
            pend_wordsize_q <= '0;
            pend_op1_q      <= '0;
            pend_instr_q    <= '0;
            pend_reg_q      <= '0;
        end else begin
            state_q         <= state_d;
            mem_valid_q     <= mem_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            is_load_q       <= is_load_d;
            rdata_q         <= rdata_d;
            wordsize_q      <= wordsize_d;
            op1_2b_q        <= op1_2b_d;
            load_instr_q    <= load_instr_d;
            reg_id_q        <= reg_id_d;
            store_done_q    <= store_done_d;
            misalign_q      <= misalign_d;
            pend_load_q     <= pend_load_d;
            pend_wordsize_q <= pend_wordsize_d;
            pend_op1_q      <= pend_op1_d;
            pend_instr_q    <= pend_instr_d;
            pend_reg_q      <= pend_reg_d;
        end
    end

    assign mem_valid_o    = mem_valid_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_wstrb_o    = mem_wstrb_q;
    assign is_load_o      = is_load_q;
    assign mem_rdata_o    = rdata_q;
    assign mem_wordsize_o = wordsize_q;
    assign reg_op1_2b_o   = op1_2b_q;
    assign load_instr_o   = load_instr_q;
    assign reg_id_o       = reg_id_q;
    assign store_done_o   = store_done_q;
    assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized requests checked
// against an arithmetic model of the access rules.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_valid_i = 1'b0, ex_is_load_i = 1'b0, ex_is_store_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic [31:0] ex_addr_i = '0, ex_wdata_i = '0, mem_rdata_i = '0;
    logic [5:0]  ex_reg_id_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        ex_ready_o, mem_valid_o, is_load_o, store_done_o, misalign_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [1:0]  mem_wordsize_o, reg_op1_2b_o;
    logic [2:0]  load_instr_o;
    logic [5:0]  reg_id_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .resetn(resetn),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_is_load_i(ex_is_load_i),
        .ex_is_store_i(ex_is_store_i), .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i), .ex_reg_id_i(ex_reg_id_i),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .is_load_o(is_load_o), .mem_rdata_o(mem_rdata_o), .mem_wordsize_o(mem_wordsize_o),
        .reg_op1_2b_o(reg_op1_2b_o), .load_instr_o(load_instr_o), .reg_id_o(reg_id_o),
        .store_done_o(store_done_o), .misalign_o(misalign_o)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        int mask = (1 << n) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = nbytes(f3);
        if (n == 1) return (d % 256) * 32'h0101_0101;
        if (n == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [1:0] model_wordsize(input logic [2:0] f3);
        int n = nbytes(f3);
        return (n == 1) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] model_instr(input logic [2:0] f3);
        if (f3 >= 3'd4) return 3'b100;
        if (nbytes(f3) == 1) return 3'b001;
        if (nbytes(f3) == 2) return 3'b010;
        return 3'b000;
    endfunction

    // One full request: drive, then check every observable step against the model.
    task automatic run_txn(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [5:0] rid,
                           input logic [31:0] rd, input int waits);
        logic [31:0] exp_addr;
        @(negedge clk);
        checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL %s ready_before got=%b exp=1", nm, ex_ready_o); end
        ex_valid_i = 1'b1; ex_is_load_i = ld; ex_is_store_i = st; ex_funct3_i = f3;
        ex_addr_i = a; ex_wdata_i = wd; ex_reg_id_i = rid;
        @(posedge clk);
        @(negedge clk);
        ex_valid_i = 1'b0;
        if (!ld && !st) begin
            checks++; if ({mem_valid_o, misalign_o, is_load_o, store_done_o, ex_ready_o} !== 5'b00001) begin
                failures++; $display("FAIL %s noop got=%b exp=00001", nm, {mem_valid_o, misalign_o, is_load_o, store_done_o, ex_ready_o}); end
            return;
        end
        if (model_misaligned(f3, a)) begin
            checks++; if ({misalign_o, mem_valid_o, ex_ready_o, is_load_o, store_done_o} !== 5'b10100) begin
                failures++; $display("FAIL %s misalign got=%b exp=10100", nm, {misalign_o, mem_valid_o, ex_ready_o, is_load_o, store_done_o}); end
            @(negedge clk);
            checks++; if ({misalign_o, mem_valid_o, ex_ready_o} !== 3'b001) begin
                failures++; $display("FAIL %s misalign_pulse got=%b exp=001", nm, {misalign_o, mem_valid_o, ex_ready_o}); end
            return;
        end
        exp_addr = a - (a % 4);
        for (int i = 0; i <= waits; i++) begin
            checks++; if ({mem_valid_o, ex_ready_o, is_load_o, store_done_o} !== 4'b1000 || mem_addr_o !== exp_addr) begin
                failures++; $display("FAIL %s wait%0d valid/ready/addr got=%b/%h exp=1000/%h", nm, i,
                    {mem_valid_o, ex_ready_o, is_load_o, store_done_o}, mem_addr_o, exp_addr); end
            checks++; if (mem_wstrb_o !== (ld ? 4'b0000 : model_wstrb(f3, a)) || (!ld && mem_wdata_o !== model_wdata(f3, wd))) begin
                failures++; $display("FAIL %s wstrb/wdata got=%b/%h exp=%b/%h", nm, mem_wstrb_o, mem_wdata_o,
                    ld ? 4'b0000 : model_wstrb(f3, a), model_wdata(f3, wd)); end
            if (i < waits) @(negedge clk);
        end
        mem_ready_i = 1'b1; mem_rdata_i = rd;
        @(posedge clk);
        @(negedge clk);
        mem_ready_i = 1'b0; mem_rdata_i = $urandom;
        checks++; if ({mem_valid_o, ex_ready_o, is_load_o, store_done_o, misalign_o} !== {2'b01, ld, !ld, 1'b0}) begin
            failures++; $display("FAIL %s complete got=%b exp=%b", nm, {mem_valid_o, ex_ready_o, is_load_o, store_done_o, misalign_o}, {2'b01, ld, !ld, 1'b0}); end
        if (ld) begin
            checks++; if (mem_rdata_o !== rd || mem_wordsize_o !== model_wordsize(f3) || reg_op1_2b_o !== a[1:0]
                          || load_instr_o !== model_instr(f3) || reg_id_o !== rid) begin
                failures++; $display("FAIL %s load_fields got=%h/%0d/%b/%b/%0d exp=%h/%0d/%b/%b/%0d", nm,
                    mem_rdata_o, mem_wordsize_o, reg_op1_2b_o, load_instr_o, reg_id_o,
                    rd, model_wordsize(f3), a[1:0], model_instr(f3), rid); end
        end
        mem_ready_i = 1'b1;  // must be ignored while idle
        @(negedge clk);
        mem_ready_i = 1'b0;
        checks++; if ({is_load_o, store_done_o, mem_valid_o} !== 3'b000) begin
            failures++; $display("FAIL %s pulse_end got=%b exp=000", nm, {is_load_o, store_done_o, mem_valid_o}); end
        if (ld) begin
            checks++; if (mem_rdata_o !== rd || reg_id_o !== rid) begin
                failures++; $display("FAIL %s hold got=%h/%0d exp=%h/%0d", nm, mem_rdata_o, reg_id_o, rd, rid); end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({mem_valid_o, is_load_o, store_done_o, misalign_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_rdata_o,
                       mem_wordsize_o, reg_op1_2b_o, load_instr_o, reg_id_o} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0", {mem_valid_o, is_load_o, store_done_o, misalign_o}); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ex_ready_o); end
    endtask

    task automatic test_directed;
        run_txn("lbu_1003", 1, 0, 3'b100, 32'h1003, 32'h0, 6'd5, 32'hAABB_CCDD, 0);
        run_txn("sh_2002", 0, 1, 3'b001, 32'h2002, 32'h0000_1234, 6'd0, 32'h0, 0);
        run_txn("lw_3001", 1, 0, 3'b010, 32'h3001, 32'h0, 6'd7, 32'h0, 0);
        run_txn("lh_4000", 1, 0, 3'b001, 32'h4000, 32'h0, 6'd9, 32'h1357_9BDF, 5);
        run_txn("ld_and_st", 1, 1, 3'b000, 32'h5001, 32'hFF, 6'd11, 32'h0102_0304, 1);
        run_txn("neither", 0, 0, 3'b010, 32'h6000, 32'h0, 6'd1, 32'h0, 0);
        run_txn("sb_7003", 0, 1, 3'b000, 32'h7003, 32'h0000_00A5, 6'd0, 32'h0, 2);
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b0; ex_is_store_i = 1'b1; ex_funct3_i = 3'b000;
        ex_addr_i = 32'h8001; ex_wdata_i = 32'h77;
        @(posedge clk);
        @(negedge clk);
        ex_valid_i = 1'b0;
        checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL rst_wait_issue got=%b exp=1", mem_valid_o); end
        resetn = 1'b0;
        #1;
        checks++; if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL rst_wait_async got=%b exp=0", mem_valid_o); end
        @(negedge clk);
        resetn = 1'b1; mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({store_done_o, is_load_o, mem_valid_o} !== 3'b000) begin
                failures++; $display("FAIL rst_wait_quiet%0d got=%b exp=000", i, {store_done_o, is_load_o, mem_valid_o}); end
        end
        mem_ready_i = 1'b0;
        run_txn("lw_after_rst", 1, 0, 3'b010, 32'h9004, 32'h0, 6'd33, 32'hCAFE_F00D, 0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_is_store_i = 1'b0; ex_funct3_i = 3'b010;
        ex_addr_i = 32'h0; ex_reg_id_i = 6'd12; mem_ready_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        ex_addr_i = 32'h4; ex_reg_id_i = 6'd13;
        checks++; if (is_load_o !== 1'b0) begin failures++; $display("FAIL b2b_gap0 got=%b exp=0", is_load_o); end
        @(negedge clk);
        checks++; if (is_load_o !== 1'b1 || reg_id_o !== 6'd12 || mem_rdata_o !== 32'h1111_1111) begin
            failures++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/12/11111111", is_load_o, reg_id_o, mem_rdata_o); end
        mem_rdata_i = 32'h2222_2222;
        @(negedge clk);
        ex_valid_i = 1'b0;
        checks++; if (is_load_o !== 1'b0 || mem_addr_o !== 32'h4) begin
            failures++; $display("FAIL b2b_gap1 got=%b/%h exp=0/00000004", is_load_o, mem_addr_o); end
        @(negedge clk);
        mem_ready_i = 1'b0;
        checks++; if (is_load_o !== 1'b1 || reg_id_o !== 6'd13 || mem_rdata_o !== 32'h2222_2222) begin
            failures++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/13/22222222", is_load_o, reg_id_o, mem_rdata_o); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 9);
            logic ld = (kind < 5) || (kind == 9);
            logic st = (kind >= 5);
            logic [2:0] f3 = ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            if (kind == 8 && n % 4 == 0) begin ld = 1'b0; st = 1'b0; end
            run_txn("random", ld, st, f3, $urandom, $urandom, 6'($urandom), $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
